// File: rtl/async_fifo1.sv
// Single-clock FIFO, 2^ASIZE x DSIZE, first-word-fall-through read port.
// Full/empty flags are registered from the next-state pointers.
module async_fifo1 #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem_q [DEPTH];

    logic [ASIZE:0] wptr_q, wptr_d;
    logic [ASIZE:0] rptr_q, rptr_d;
    logic           wfull_q, wfull_d;
    logic           rempty_q, rempty_d;
    logic           wr_en, rd_en;

    always_comb begin
        wr_en    = winc && !wfull_q;
        rd_en    = rinc && !rempty_q;
        wptr_d   = wptr_q + {{ASIZE{1'b0}}, wr_en};
        rptr_d   = rptr_q + {{ASIZE{1'b0}}, rd_en};
        rempty_d = (rptr_d == wptr_d);
        // Full when the pointers differ only in the wrap bit
        wfull_d  = (wptr_d == {~rptr_d[ASIZE], rptr_d[ASIZE-1:0]});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            wfull_q  <= wfull_d;
            rempty_q <= rempty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wptr_q[ASIZE-1:0]] <= wdata;
        end
    end

    assign rdata  = mem_q[rptr_q[ASIZE-1:0]];
    assign wfull  = wfull_q;
    assign rempty = rempty_q;

endmodule

// File: tb/tb_async_fifo1.sv
// Self-checking bench for async_fifo1: table vectors, directed corner cases,
// and randomized traffic against a queue-based reference model.
module tb_async_fifo1;

    localparam int DSIZE = 8;
    localparam int ASIZE = 4;
    localparam int DEPTH = 1 << ASIZE;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             winc = 1'b0;
    logic             rinc = 1'b0;
    logic [DSIZE-1:0] wdata = '0;
    logic [DSIZE-1:0] rdata;
    logic             wfull;
    logic             rempty;

    int checks = 0;
    int errors = 0;

    logic [DSIZE-1:0] model_q [$];

    typedef struct {
        logic             v_rst;
        logic             v_winc;
        logic             v_rinc;
        logic [DSIZE-1:0] v_wdata;
        logic             e_rempty;
        logic             e_wfull;
        logic             chk_data;
        logic [DSIZE-1:0] e_rdata;
    } vec_t;

    vec_t vecs [10];

    async_fifo1 #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .clk    (clk),
        .rst    (rst),
        .winc   (winc),
        .wdata  (wdata),
        .wfull  (wfull),
        .rinc   (rinc),
        .rdata  (rdata),
        .rempty (rempty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: apply inputs, advance the reference model, compare after the edge.
    task automatic cycle(input logic r, input logic w, input logic rd, input logic [DSIZE-1:0] d);
        bit w_ok, r_ok;
        rst   = r;
        winc  = w;
        rinc  = rd;
        wdata = d;
        @(posedge clk);
        #1;
        if (r) begin
            model_q.delete();
        end else begin
            w_ok = w && (model_q.size() < DEPTH);
            r_ok = rd && (model_q.size() > 0);
            if (r_ok) void'(model_q.pop_front());
            if (w_ok) model_q.push_back(d);
        end
        check("model_rempty", {31'b0, rempty}, {31'b0, model_q.size() == 0});
        check("model_wfull", {31'b0, wfull}, {31'b0, model_q.size() == DEPTH});
        if (model_q.size() > 0)
            check("model_rdata", {24'b0, rdata}, {24'b0, model_q[0]});
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 8'h77};
        vecs[9] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};

        // Reset with requests held, single word, empty-simultaneous access
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].v_rst, vecs[i].v_winc, vecs[i].v_rinc, vecs[i].v_wdata);
            check($sformatf("vec%0d_rempty", i), {31'b0, rempty}, {31'b0, vecs[i].e_rempty});
            check($sformatf("vec%0d_wfull", i), {31'b0, wfull}, {31'b0, vecs[i].e_wfull});
            if (vecs[i].chk_data)
                check($sformatf("vec%0d_rdata", i), {24'b0, rdata}, {24'b0, vecs[i].e_rdata});
        end

        // Fill, overflow attempts, drain, underflow attempts
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'(i));
            if (i == DEPTH - 2) check("fill_not_full_15", {31'b0, wfull}, 32'd0);
        end
        check("fill_full_16", {31'b0, wfull}, 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 8'hFF);
        cycle(1'b0, 1'b1, 1'b0, 8'hFF);
        check("overflow_still_full", {31'b0, wfull}, 32'd1);
        check("overflow_head", {24'b0, rdata}, 32'h00);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain_%0d", i), {24'b0, rdata}, 32'(i));
            cycle(1'b0, 1'b0, 1'b1, '0);
            if (i == 0) check("drain_full_drop", {31'b0, wfull}, 32'd0);
        end
        check("drain_empty", {31'b0, rempty}, 32'd1);
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, 1'b1, '0);
        check("underflow_empty", {31'b0, rempty}, 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 8'h42);
        check("after_underflow_rdata", {24'b0, rdata}, 32'h42);
        cycle(1'b0, 1'b0, 1'b1, '0);

        // Wrap-around: alternating write and read cycles
        for (int i = 0; i < 128; i++) begin
            if (i % 2 == 0) cycle(1'b0, 1'b1, 1'b0, 8'($urandom));
            else            cycle(1'b0, 1'b0, 1'b1, '0);
        end
        check("wrap_empty", {31'b0, rempty}, 32'd1);

        // Occupancy 8 with simultaneous access for 5 cycles
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, 8'(8'hC0 + i));
        check("occ8_size", model_q.size(), 32'd8);
        check("occ8_head", {24'b0, rdata}, 32'h85);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, '0);
        check("occ8_drained", {31'b0, rempty}, 32'd1);

        // Full with both requests: read taken, write dropped
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
        check("full_both_pre", {31'b0, wfull}, 32'd1);
        cycle(1'b0, 1'b1, 1'b1, 8'hEE);
        check("full_both_wfull", {31'b0, wfull}, 32'd0);
        check("full_both_head", {24'b0, rdata}, 32'h21);
        for (int i = 0; i < DEPTH - 1; i++) begin
            check($sformatf("full_both_drain_%0d", i), {24'b0, rdata}, 32'(8'h21 + i));
            cycle(1'b0, 1'b0, 1'b1, '0);
        end
        check("full_both_dropped", {31'b0, rempty}, 32'd1);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h50 + i));
        cycle(1'b1, 1'b0, 1'b0, '0);
        check("midrst_rempty", {31'b0, rempty}, 32'd1);
        check("midrst_wfull", {31'b0, wfull}, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 8'h3C);
        check("midrst_first", {24'b0, rdata}, 32'h3C);
        cycle(1'b0, 1'b0, 1'b1, '0);
        check("midrst_empty", {31'b0, rempty}, 32'd1);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom), 8'($urandom));
        end

        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
